// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the CPU cache/MEM stage and
// an 8-bit external RAM. It arbitrates IF word-fetch misses against data
// loads/stores (MEM wins), and splits each 1/2/4-byte access into consecutive
// byte transactions. Load bytes are reassembled little-endian. Completion is
// signalled by a one-cycle done pulse to the requester.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr/if_flush  IF word-load request, byte address, cancel
//   if_done/if_data          IF completion pulse and fetched word
//   mem_req/mem_wr_en/mem_sel/mem_addr/mem_wdata
//                            data request: store flag, size (01 B, 10 H,
//                            11 W, 00 no-op), byte address, store data
//   mem_done/mem_rdata       data completion pulse and zero-extended load data
//   ram_din                  RAM read byte, valid one cycle after ram_a
//   ram_dout/ram_a/ram_wr    registered RAM write byte, address, write strobe
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_wr_en,
  input  logic [1:0]            mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  src_if_q, src_if_d;   // 1 = IF access, 0 = MEM access
  logic                  wr_q, wr_d;
  logic [2:0]            n_q, n_d;             // byte count of the access
  logic [2:0]            k_q, k_d;             // index of the byte on ram_a
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;     // load assembly buffer
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;

  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

  always_comb begin
    state_d     = state_q;
    src_if_d    = src_if_q;
    wr_d        = wr_q;
    n_d         = n_q;
    k_d         = k_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    // RAM port is idle unless a byte is explicitly issued below
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    if_done     = 1'b0;
    mem_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          src_if_d = 1'b0;
          base_d   = mem_addr;
          wr_d     = mem_wr_en;
          wdata_d  = mem_wdata;
          rdata_d  = '0;
          k_d      = '0;
          case (mem_sel)
            2'b01:   n_d = 3'd1;
            2'b10:   n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
          if (mem_sel == 2'b00) begin
            state_d     = S_DONE;
            mem_rdata_d = '0;
          end else begin
            // Byte 0 is issued straight from the request so it appears on
            // the RAM port in the first ACCESS cycle.
            state_d    = S_ACCESS;
            ram_a_d    = mem_addr;
            ram_wr_d   = mem_wr_en;
            ram_dout_d = mem_wr_en ? mem_wdata[7:0] : 8'h00;
          end
        end else if (if_req && !if_flush) begin
          src_if_d = 1'b1;
          base_d   = if_addr;
          wr_d     = 1'b0;
          n_d      = 3'd4;
          k_d      = '0;
          rdata_d  = '0;
          state_d  = S_ACCESS;
          ram_a_d  = if_addr;
        end
      end

      S_ACCESS: begin
        if (src_if_q && if_flush) begin
          state_d = S_IDLE;
        end else if (wr_q) begin
          if (k_q == n_q - 3'd1) begin
            state_d     = S_DONE;
            mem_rdata_d = '0;
          end else begin
            k_d      = k_q + 3'd1;
            ram_a_d  = base_q + ADDR_WIDTH'(k_q + 3'd1);
            ram_wr_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
              if (k_q + 3'd1 == 3'(i)) ram_dout_d = wdata_q[8*i +: 8];
            end
          end
        end else begin
          // ram_din now carries the byte issued one cycle ago (index k-1)
          for (int i = 0; i < 4; i++) begin
            if (k_q == 3'(i + 1)) rdata_d[8*i +: 8] = ram_din;
          end
          if (k_q == n_q) begin
            state_d = S_DONE;
            if (src_if_q) if_data_d   = rdata_d;
            else          mem_rdata_d = rdata_d;
          end else begin
            k_d = k_q + 3'd1;
            // the extra capture cycle after the last issue leaves ram_a idle
            if (k_q + 3'd1 < n_q) ram_a_d = base_q + ADDR_WIDTH'(k_q + 3'd1);
          end
        end
      end

      S_DONE: begin
        if (src_if_q) if_done  = !if_flush;
        else          mem_done = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      src_if_q    <= 1'b0;
      wr_q        <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_if_q    <= src_if_d;
      wr_q        <= wr_d;
      n_q         <= n_d;
      k_q         <= k_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  // Per-access datapath latches; always rewritten on accept before use.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [16:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_wr_en;
  logic [1:0]  mem_sel;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [16:0] ram_a;
  logic        ram_wr;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_done_cnt = 0;
  int if_done_cnt  = 0;

  logic [7:0]  ram [0:131071];
  logic [16:0] tr_a [1:20];
  logic [7:0]  tr_d [1:20];

  mem_ctrl #(.ADDR_WIDTH(17)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_done  (if_done),
    .if_data  (if_data),
    .mem_req  (mem_req),
    .mem_wr_en(mem_wr_en),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  always @(negedge clk) begin
    if (mem_done) mem_done_cnt <= mem_done_cnt + 1;
    if (if_done)  if_done_cnt  <= if_done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One MEM transaction; lat = done cycle index after the accepting edge
  // (0 if no done within the budget). Requester drops req after done.
  task automatic mem_xfer(input logic wr, input logic [1:0] sel, input logic [16:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output int wrc);
    mem_wr_en = wr; mem_sel = sel; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
    @(posedge clk);
    lat = 0; rd = '0; wrc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tr_a[c] = ram_a;
      tr_d[c] = ram_dout;
      if (ram_wr) wrc++;
      if (mem_done) begin
        lat = c;
        rd  = mem_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_req = 1'b0; mem_wr_en = 1'b0; mem_sel = 2'b00;
  endtask

  int          lat, wrc, m_lat, i_lat, d0;
  logic [31:0] rd, m_rd, i_rd;

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
    mem_req = 0; mem_wr_en = 0; mem_sel = 2'b00; mem_addr = '0; mem_wdata = '0;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_if_done",   32'(if_done), 32'h0);
    check_eq("rst_mem_done",  32'(mem_done), 32'h0);
    check_eq("rst_if_data",   if_data, 32'h0);
    check_eq("rst_mem_rdata", mem_rdata, 32'h0);
    check_eq("rst_ram_a",     32'(ram_a), 32'h0);
    check_eq("rst_ram_dout",  32'(ram_dout), 32'h0);
    check_eq("rst_ram_wr",    32'(ram_wr), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store then word load at 0x10
    mem_xfer(1'b1, 2'b11, 17'h00010, 32'h44332211, lat, rd, wrc);
    check_eq("st_w_lat", 32'(lat), 32'd5);
    check_eq("st_w_wrc", 32'(wrc), 32'd4);
    mem_xfer(1'b0, 2'b11, 17'h00010, 32'h0, lat, rd, wrc);
    check_eq("ld_w_lat", 32'(lat), 32'd6);
    check_eq("ld_w_data", rd, 32'h44332211);
    check_eq("ld_w_wrc", 32'(wrc), 32'd0);
    for (int i = 0; i < 4; i++) check_eq("ld_w_addr", 32'(tr_a[i+1]), 32'h10 + 32'(i));
    @(negedge clk);
    check_eq("post_done_idle", 32'(mem_done), 32'h0);
    check_eq("post_done_ram_a", 32'(ram_a), 32'h0);

    // Half store wrapping past the top of the address space
    mem_xfer(1'b1, 2'b10, 17'h1FFFF, 32'h0000BEEF, lat, rd, wrc);
    check_eq("st_h_lat", 32'(lat), 32'd3);
    check_eq("st_h_wrc", 32'(wrc), 32'd2);
    check_eq("st_h_a0", 32'(tr_a[1]), 32'h1FFFF);
    check_eq("st_h_a1", 32'(tr_a[2]), 32'h0);
    check_eq("st_h_d0", 32'(tr_d[1]), 32'hEF);
    check_eq("st_h_d1", 32'(tr_d[2]), 32'hBE);
    check_eq("st_h_ram_top", 32'(ram[17'h1FFFF]), 32'hEF);
    check_eq("st_h_ram_zero", 32'(ram[17'h00000]), 32'hBE);
    mem_xfer(1'b0, 2'b10, 17'h1FFFF, 32'h0, lat, rd, wrc);
    check_eq("ld_h_lat", 32'(lat), 32'd4);
    check_eq("ld_h_data", rd, 32'h0000BEEF);

    // Preload for arbitration and flush
    mem_xfer(1'b1, 2'b01, 17'h00005, 32'hFFFFFF80, lat, rd, wrc);
    check_eq("st_b_lat", 32'(lat), 32'd2);
    check_eq("st_b_wrc", 32'(wrc), 32'd1);
    mem_xfer(1'b1, 2'b11, 17'h00020, 32'hD4C3B2A1, lat, rd, wrc);

    // Simultaneous requests: MEM byte load first, IF word afterwards
    mem_wr_en = 0; mem_sel = 2'b01; mem_addr = 17'h5; mem_req = 1;
    if_addr = 17'h20; if_req = 1;
    @(posedge clk);
    m_lat = 0; i_lat = 0; m_rd = '0; i_rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_done && m_lat == 0) begin m_lat = c; m_rd = mem_rdata; end
      if (if_done && i_lat == 0) begin i_lat = c; i_rd = if_data; end
      @(posedge clk); #1;
      if (m_lat == c) begin mem_req = 0; mem_sel = 2'b00; end
      if (i_lat == c) begin if_req = 0; break; end
    end
    if_req = 0; mem_req = 0;
    check_eq("arb_mem_lat", 32'(m_lat), 32'd3);
    check_eq("arb_mem_data", m_rd, 32'h00000080);
    check_eq("arb_if_lat", 32'(i_lat), 32'd10);
    check_eq("arb_if_data", i_rd, 32'hD4C3B2A1);

    // IF fetch flushed in its third ACCESS cycle
    d0 = if_done_cnt;
    if_addr = 17'h20; if_req = 1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    if_flush = 1; if_req = 0;
    @(posedge clk); #1;
    if_flush = 0;
    @(negedge clk);
    check_eq("flush_ram_a", 32'(ram_a), 32'h0);
    check_eq("flush_ram_wr", 32'(ram_wr), 32'h0);
    mem_xfer(1'b0, 2'b10, 17'h00020, 32'h0, lat, rd, wrc);
    check_eq("flush_mem_lat", 32'(lat), 32'd4);
    check_eq("flush_mem_data", rd, 32'h0000B2A1);
    repeat (4) @(negedge clk);
    check_eq("flush_no_if_done", 32'(if_done_cnt - d0), 32'd0);

    // Reset in the middle of a word store
    mem_xfer(1'b1, 2'b11, 17'h00040, 32'h88776655, lat, rd, wrc);
    mem_wr_en = 1; mem_sel = 2'b11; mem_addr = 17'h40; mem_wdata = 32'hCAFEF00D; mem_req = 1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("rstmid_wr_before", 32'(ram_wr), 32'h1);
    d0 = mem_done_cnt;
    rst = 0; mem_req = 0; mem_wr_en = 0; mem_sel = 2'b00;
    #1;
    check_eq("rstmid_ram_wr", 32'(ram_wr), 32'h0);
    check_eq("rstmid_ram_a", 32'(ram_a), 32'h0);
    check_eq("rstmid_ram_dout", 32'(ram_dout), 32'h0);
    check_eq("rstmid_mem_rdata", mem_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check_eq("rstmid_no_done", 32'(mem_done_cnt - d0), 32'd0);
    check_eq("rstmid_ram42", 32'(ram[17'h42]), 32'h77);
    mem_xfer(1'b0, 2'b11, 17'h00040, 32'h0, lat, rd, wrc);
    check_eq("rstmid_ld_lat", 32'(lat), 32'd6);
    check_eq("rstmid_ld_data", rd, 32'h8877F00D);

    // No-op request
    mem_xfer(1'b0, 2'b00, 17'h00123, 32'h0, lat, rd, wrc);
    check_eq("noop_lat", 32'(lat), 32'd1);
    check_eq("noop_data", rd, 32'h0);
    check_eq("noop_wrc", 32'(wrc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
